beat_recorder: RTL
==================

// Module: beat_recorder
// PURPOSE
//  Capture side of the note record/playback path: samples the live keyboard note (ascii) on a fixed
//  time tick and writes run-length entries {note, duration} into one of two recording slots.
//  The playback chooser reads finished slots through the registered read port and uses
//  slotN_valid / slotN_len to drive the saved-recording buzzers.
// PARAMETERS
//  TICK_DIV  500000  clk cycles per duration tick (10 ms at 50 MHz); >=2
//  DUR_W     8       duration field width; max run per entry = 2^DUR_W-1 ticks
//  ADDR_W    6       entry address width; DEPTH = 2^ADDR_W entries per slot
// PORTS
//  clk          in   1           system clock
//  reset        in   1           synchronous, active-high reset
//  ascii        in   7           current key note code; 0 = silence (recorded as a rest)
//  slot_sel     in   2           SW toggle: bit0 -> slot 0, bit1 -> slot 1; both set -> slot 0
//  record_req   in   1           1-cycle pulse: start recording into selected slot
//  stop_req     in   1           1-cycle pulse: end current recording
//  recording    out  1           high while capturing
//  rec_slot     out  1           slot being captured (valid when recording)
//  done         out  1           1-cycle pulse when a recording is committed
//  full         out  1           1-cycle pulse when recording ended because slot filled
//  slot0_valid  out  1           slot 0 holds a committed recording
//  slot1_valid  out  1           slot 1 holds a committed recording
//  slot0_len    out  ADDR_W+1    entries in slot 0 (0..DEPTH)
//  slot1_len    out  ADDR_W+1    entries in slot 1
//  rd_slot      in   1           read slot select
//  rd_addr      in   ADDR_W      read entry address
//  rd_data      out  7+DUR_W     {note[6:0], dur[DUR_W-1:0]}, valid 1 cycle after rd_slot/rd_addr
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0; aborts any capture. RAM contents not cleared.
//  Storage: 2*DEPTH x (7+DUR_W) array, index {slot, addr}; one write port (FSM), one read port.
//  FSM IDLE: record_req with slot_sel!=0 -> REC; target slot latched; that slot's valid and len
//   cleared same edge; wr_ptr=0, dur_cnt=0, tick counter=0, cur_note=ascii. record_req with
//   slot_sel==0 ignored. stop_req in IDLE ignored.
//  FSM REC: tick asserts every TICK_DIV cycles (first tick TICK_DIV cycles after entry). On tick:
//   - dur_cnt==0: cur_note<=ascii, dur_cnt<=1, no write.
//   - ascii!=cur_note, or dur_cnt==2^DUR_W-1: write {cur_note,dur_cnt} at wr_ptr, wr_ptr++,
//     cur_note<=ascii, dur_cnt<=1 (saturated run continues as new entry of same note).
//   - else dur_cnt++.
//   Note changes are quantised to ticks; changes between ticks that revert are not recorded.
//   record_req during REC ignored. If a write makes wr_ptr==DEPTH -> COMMIT with full pulse
//   (no flush write).
//  stop_req in REC -> FLUSH; stop wins over a same-cycle tick (that tick's update discarded).
//  FLUSH (1 cycle): if dur_cnt!=0 write final {cur_note,dur_cnt}, wr_ptr++ -> COMMIT.
//  COMMIT (1 cycle): slotN_len<=wr_ptr, slotN_valid<=1 (even if len 0), done=1 -> IDLE.
//   full pulses in the same cycle as done when ended by overflow.
//  recording high in REC and FLUSH; rec_slot holds latched slot. Other slot untouched throughout.
//  Read: rd_data registered, 1-cycle latency, independent of FSM; reading the slot under capture
//   returns partial data (its valid is 0). Same-address read/write: old data returned.
// TESTING (sim TICK_DIV=4)
//  1 reset asserted mid-REC -> next cycle recording=0, slot0/1_valid=0, lens=0, done=0.
//  2 slot_sel=01, record_req, ascii=0x61 3 ticks, 0x62 2 ticks, stop -> slot0 entries
//    {0x61,3},{0x62,2}; slot0_len=2, slot0_valid=1, done 1 cycle, full=0.
//  3 slot_sel=11 -> captures into slot 0; slot_sel=00 record_req -> recording stays 0.
//  4 DUR_W=8, hold 0x63 for 300 ticks, stop -> entries {0x63,255},{0x63,45}, len=2.
//  5 ADDR_W=2, change ascii every tick -> after 4 writes auto-commit: len=4, full and done pulse
//    same cycle; subsequent stop_req ignored.
//  6 record slot1 while slot0 valid -> slot0 data/len unchanged; stop and tick same cycle ->
//    final entry excludes that tick; rd_data matches 1 cycle after rd_addr change.

Source files
------------

// File: rtl/beat_recorder.sv
// beat_recorder: samples the live note on a fixed tick and stores
// run-length {note, dur} entries into one of two recording slots.
module beat_recorder #(
  parameter int TICK_DIV = 500000,
  parameter int DUR_W    = 8,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        ascii,
  input  logic [1:0]        slot_sel,
  input  logic              record_req,
  input  logic              stop_req,
  output logic              recording,
  output logic              rec_slot,
  output logic              done,
  output logic              full,
  output logic              slot0_valid,
  output logic              slot1_valid,
  output logic [ADDR_W:0]   slot0_len,
  output logic [ADDR_W:0]   slot1_len,
  input  logic              rd_slot,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [6+DUR_W:0]  rd_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW    = $clog2(TICK_DIV);
  localparam int EW    = 7 + DUR_W;

  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0]    TICK_ONE  = TW'(1);
  localparam logic [DUR_W-1:0] DUR_MAX   = '1;
  localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
  localparam logic [ADDR_W:0]  PTR_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]  PTR_FULL  = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REC,
    FLUSH,
    COMMIT
  } state_t;

  state_t state, state_nx;

  logic [TW-1:0]     tick_cnt, tick_cnt_nx;
  logic [6:0]        cur_note, cur_note_nx;
  logic [DUR_W-1:0]  dur_cnt, dur_cnt_nx;
  logic [ADDR_W:0]   wr_ptr, wr_ptr_nx;
  logic [ADDR_W:0]   ptr_inc;
  logic              slot_q, slot_nx;
  logic              full_q, full_nx;
  logic              tick;
  logic              start;
  logic              commit;
  logic              wr_en;
  logic [EW-1:0]     wr_data;

  logic [EW-1:0] mem [2*DEPTH];

  assign tick    = (tick_cnt == TICK_LAST);
  assign ptr_inc = wr_ptr + PTR_ONE;
  assign wr_data = {cur_note, dur_cnt};

  always_comb begin
    state_nx    = state;
    tick_cnt_nx = tick_cnt;
    cur_note_nx = cur_note;
    dur_cnt_nx  = dur_cnt;
    wr_ptr_nx   = wr_ptr;
    slot_nx     = slot_q;
    full_nx     = full_q;
    start       = 1'b0;
    commit      = 1'b0;
    wr_en       = 1'b0;
    unique case (state)
      IDLE: begin
        if (record_req && slot_sel != 2'b00) begin
          state_nx    = REC;
          start       = 1'b1;
          slot_nx     = ~slot_sel[0];
          tick_cnt_nx = '0;
          dur_cnt_nx  = '0;
          wr_ptr_nx   = '0;
          cur_note_nx = ascii;
          full_nx     = 1'b0;
        end
      end
      REC: begin
        // stop beats a same-cycle tick; the tick is simply dropped
        if (stop_req) begin
          state_nx = FLUSH;
        end else begin
          tick_cnt_nx = tick ? '0 : tick_cnt + TICK_ONE;
          if (tick) begin
            if (dur_cnt == '0) begin
              cur_note_nx = ascii;
              dur_cnt_nx  = DUR_ONE;
            end else if (ascii != cur_note || dur_cnt == DUR_MAX) begin
              wr_en       = 1'b1;
              wr_ptr_nx   = ptr_inc;
              cur_note_nx = ascii;
              dur_cnt_nx  = DUR_ONE;
              if (ptr_inc == PTR_FULL) begin
                state_nx = COMMIT;
                full_nx  = 1'b1;
              end
            end else begin
              dur_cnt_nx = dur_cnt + DUR_ONE;
            end
          end
        end
      end
      FLUSH: begin
        if (dur_cnt != '0) begin
          wr_en     = 1'b1;
          wr_ptr_nx = ptr_inc;
        end
        state_nx = COMMIT;
      end
      COMMIT: begin
        commit   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      cur_note <= '0;
      dur_cnt  <= '0;
      wr_ptr   <= '0;
      slot_q   <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick_cnt_nx;
      cur_note <= cur_note_nx;
      dur_cnt  <= dur_cnt_nx;
      wr_ptr   <= wr_ptr_nx;
      slot_q   <= slot_nx;
      full_q   <= full_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_valid <= 1'b0;
      slot1_valid <= 1'b0;
      slot0_len   <= '0;
      slot1_len   <= '0;
    end else begin
      if (start) begin
        if (slot_nx) begin
          slot1_valid <= 1'b0;
          slot1_len   <= '0;
        end else begin
          slot0_valid <= 1'b0;
          slot0_len   <= '0;
        end
      end
      if (commit) begin
        if (slot_q) begin
          slot1_valid <= 1'b1;
          slot1_len   <= wr_ptr;
        end else begin
          slot0_valid <= 1'b1;
          slot0_len   <= wr_ptr;
        end
      end
    end
  end

  // RAM has no reset; contents survive a reset
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[{slot_q, wr_ptr[ADDR_W-1:0]}] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[{rd_slot, rd_addr}];
    end
  end

  assign recording = (state == REC) || (state == FLUSH);
  assign rec_slot  = slot_q;
  assign done      = (state == COMMIT);
  assign full      = (state == COMMIT) && full_q;

endmodule
